// File: rtl/video_stream_pkg.sv
//==============================================================================
// Module : video_stream_pkg
// Shared state encodings and default geometry for the video stream blocks.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package video_stream_pkg;

   localparam int DEF_N      = 8;
   localparam int DEF_WIDTH  = 10;
   localparam int DEF_HEIGHT = 10;
   localparam int DEF_ADDR_W = 20;

   typedef enum logic [1:0] {
      RX_IDLE     = 2'd0,
      RX_ACTIVE   = 2'd1,
      RX_DROP_EOL = 2'd2
   } rx_state_t;

   typedef enum logic [1:0] {
      SRC_IDLE   = 2'd0,
      SRC_ACTIVE = 2'd1,
      SRC_HBLANK = 2'd2,
      SRC_VBLANK = 2'd3
   } src_state_t;

endpackage

`default_nettype wire

// File: rtl/video_pos_counter.sv
//==============================================================================
// Module : video_pos_counter
// Pixel/line position tracking with an incremental line-base address.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module video_pos_counter #(
   parameter int width  = 10,
   parameter int height = 10,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_inc,
   input  logic              i_eol,
   input  logic              i_sof_restart,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last_pix,
   output logic              o_last_line
);

   localparam int XW = $clog2(width);
   localparam int YW = (height > 1) ? $clog2(height) : 1;
   localparam logic [XW-1:0] c_LAST_X = XW'(width - 1);
   localparam logic [YW-1:0] c_LAST_Y = YW'(height - 1);

   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [ADDR_W-1:0] r_base;

   // A restart consumes the pixel at address 0, so the next position is x=1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_base <= '0;
      end else if (i_sof_restart) begin
         r_x    <= XW'(1);
         r_y    <= '0;
         r_base <= '0;
      end else if (i_eol) begin
         r_x <= '0;
         if (o_last_line) begin
            r_y    <= '0;
            r_base <= '0;
         end else begin
            r_y    <= r_y + YW'(1);
            r_base <= r_base + ADDR_W'(width);
         end
      end else if (i_inc) begin
         r_x <= r_x + XW'(1);
      end
   end

   assign o_addr      = r_base + ADDR_W'(r_x);
   assign o_last_pix  = (r_x == c_LAST_X);
   assign o_last_line = (r_y == c_LAST_Y);

endmodule

`default_nettype wire

// File: rtl/video_stream_receiver.sv
//==============================================================================
// Module : video_stream_receiver
// AXI4-Stream video sink writing accepted pixels to a linear frame buffer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module video_stream_receiver
   import video_stream_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int width  = DEF_WIDTH,
   parameter int height = DEF_HEIGHT,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              sys_clk,
   input  logic              sys_aresetn,
   input  logic              en,
   input  logic [N-1:0]      s_video_tdata,
   input  logic              s_video_tvalid,
   input  logic              s_video_tlast,
   input  logic              s_video_tuser,
   output logic              s_video_tready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [N-1:0]      wr_data,
   output logic              frame_done,
   output logic [15:0]       frame_cnt,
   input  logic              err_clr,
   output logic              err_sof_early,
   output logic              err_eol_early,
   output logic              err_eol_late,
   output logic [15:0]       err_cnt
);

   rx_state_t r_state, w_next_state;

   logic              r_tready;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [N-1:0]      r_wr_data;
   logic              r_frame_done;
   logic [15:0]       r_frame_cnt;
   logic              r_err_sof, r_err_early, r_err_late;
   logic [15:0]       r_err_cnt;

   logic              w_beat;
   logic              w_wr, w_wr_zero, w_inc, w_eol, w_sof, w_done;
   logic              w_err_sof, w_err_early, w_err_late, w_err_any;
   logic [ADDR_W-1:0] w_pos_addr;
   logic              w_last_pix, w_last_line;

   assign w_beat = s_video_tvalid & r_tready;

   video_pos_counter #(
      .width  (width),
      .height (height),
      .ADDR_W (ADDR_W)
   ) u_pos (
      .clk           (sys_clk),
      .rst_n         (sys_aresetn),
      .i_inc         (w_inc),
      .i_eol         (w_eol),
      .i_sof_restart (w_sof),
      .o_addr        (w_pos_addr),
      .o_last_pix    (w_last_pix),
      .o_last_line   (w_last_line)
   );

   always_ff @(posedge sys_clk or negedge sys_aresetn) begin
      if (!sys_aresetn) r_state <= RX_IDLE;
      else              r_state <= w_next_state;
   end

   // tuser is checked first in every state so one beat yields at most one error.
   always_comb begin
      w_next_state = r_state;
      w_wr         = 1'b0;
      w_wr_zero    = 1'b0;
      w_inc        = 1'b0;
      w_eol        = 1'b0;
      w_sof        = 1'b0;
      w_done       = 1'b0;
      w_err_sof    = 1'b0;
      w_err_early  = 1'b0;
      w_err_late   = 1'b0;
      if (w_beat) begin
         case (r_state)
            RX_IDLE: begin
               if (s_video_tuser) begin
                  w_wr         = 1'b1;
                  w_wr_zero    = 1'b1;
                  w_sof        = 1'b1;
                  w_next_state = RX_ACTIVE;
               end
            end
            RX_ACTIVE: begin
               if (s_video_tuser) begin
                  w_err_sof = 1'b1;
                  w_wr      = 1'b1;
                  w_wr_zero = 1'b1;
                  w_sof     = 1'b1;
               end else if (w_last_pix) begin
                  if (s_video_tlast) begin
                     w_wr  = 1'b1;
                     w_eol = 1'b1;
                     if (w_last_line) begin
                        w_done       = 1'b1;
                        w_next_state = RX_IDLE;
                     end
                  end else begin
                     w_err_late   = 1'b1;
                     w_next_state = RX_DROP_EOL;
                  end
               end else if (s_video_tlast) begin
                  w_err_early = 1'b1;
                  w_wr        = 1'b1;
                  w_eol       = 1'b1;
                  if (w_last_line) w_next_state = RX_IDLE;
               end else begin
                  w_wr  = 1'b1;
                  w_inc = 1'b1;
               end
            end
            RX_DROP_EOL: begin
               if (s_video_tuser) begin
                  w_err_sof    = 1'b1;
                  w_wr         = 1'b1;
                  w_wr_zero    = 1'b1;
                  w_sof        = 1'b1;
                  w_next_state = RX_ACTIVE;
               end else if (s_video_tlast) begin
                  w_eol        = 1'b1;
                  w_next_state = w_last_line ? RX_IDLE : RX_ACTIVE;
               end
            end
            default: w_next_state = RX_IDLE;
         endcase
      end
   end

   assign w_err_any = w_err_sof | w_err_early | w_err_late;

   always_ff @(posedge sys_clk or negedge sys_aresetn) begin
      if (!sys_aresetn) begin
         r_tready     <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_tready     <= en;
         r_wr_en      <= w_wr;
         r_wr_addr    <= w_wr_zero ? '0 : w_pos_addr;
         r_wr_data    <= s_video_tdata;
         r_frame_done <= w_done;
         if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   // An error arriving together with err_clr survives the clear.
   always_ff @(posedge sys_clk or negedge sys_aresetn) begin
      if (!sys_aresetn) begin
         r_err_sof   <= 1'b0;
         r_err_early <= 1'b0;
         r_err_late  <= 1'b0;
         r_err_cnt   <= '0;
      end else if (err_clr) begin
         r_err_sof   <= w_err_sof;
         r_err_early <= w_err_early;
         r_err_late  <= w_err_late;
         r_err_cnt   <= {15'd0, w_err_any};
      end else begin
         r_err_sof   <= r_err_sof   | w_err_sof;
         r_err_early <= r_err_early | w_err_early;
         r_err_late  <= r_err_late  | w_err_late;
         if (w_err_any && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign s_video_tready = r_tready;
   assign wr_en          = r_wr_en;
   assign wr_addr        = r_wr_addr;
   assign wr_data        = r_wr_data;
   assign frame_done     = r_frame_done;
   assign frame_cnt      = r_frame_cnt;
   assign err_sof_early  = r_err_sof;
   assign err_eol_early  = r_err_early;
   assign err_eol_late   = r_err_late;
   assign err_cnt        = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_video_stream_receiver.sv
//==============================================================================
// Module : tb_video_stream_receiver
// Scoreboard bench for video_stream_receiver with a behavioural framing model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_video_stream_receiver;

   localparam int W  = 10;
   localparam int H  = 10;
   localparam int AW = 20;

   logic          sys_clk = 1'b0;
   logic          sys_aresetn;
   logic          en;
   logic [7:0]    s_video_tdata;
   logic          s_video_tvalid;
   logic          s_video_tlast;
   logic          s_video_tuser;
   logic          s_video_tready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          frame_done;
   logic [15:0]   frame_cnt;
   logic          err_clr;
   logic          err_sof_early;
   logic          err_eol_early;
   logic          err_eol_late;
   logic [15:0]   err_cnt;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
      logic          fd;
   } wr_t;

   wr_t q[$];
   wr_t mon_e;

   int n_checks = 0;
   int n_fail   = 0;

   int          m_state = 0;
   int          mx = 0;
   int          my = 0;
   logic [15:0] m_fcnt = '0;
   logic [15:0] m_ecnt = '0;
   bit          m_sof = 0, m_early = 0, m_late = 0;

   video_stream_receiver #(
      .N      (8),
      .width  (W),
      .height (H),
      .ADDR_W (AW)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_aresetn    (sys_aresetn),
      .en             (en),
      .s_video_tdata  (s_video_tdata),
      .s_video_tvalid (s_video_tvalid),
      .s_video_tlast  (s_video_tlast),
      .s_video_tuser  (s_video_tuser),
      .s_video_tready (s_video_tready),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .frame_done     (frame_done),
      .frame_cnt      (frame_cnt),
      .err_clr        (err_clr),
      .err_sof_early  (err_sof_early),
      .err_eol_early  (err_eol_early),
      .err_eol_late   (err_eol_late),
      .err_cnt        (err_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge sys_clk) begin
      if (wr_en) begin
         check_eq("sb_has_entry", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            check_eq("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
            check_eq("wr_data", 32'(wr_data), 32'(mon_e.data));
            check_eq("frame_done", 32'(frame_done), 32'(mon_e.fd));
         end
      end else begin
         check_eq("frame_done_no_wr", 32'(frame_done), 32'd0);
      end
   end

   task automatic model_clear();
      m_sof = 0; m_early = 0; m_late = 0; m_ecnt = '0;
   endtask

   task automatic model_beat(input logic [7:0] d, input bit u, input bit l, input bit clr);
      bit wr = 0, fd = 0, es = 0, ee = 0, el = 0;
      int a = 0;
      case (m_state)
         0: if (u) begin wr = 1; a = 0; mx = 1; my = 0; m_state = 1; end
         1: begin
            if (u) begin
               es = 1; wr = 1; a = 0; mx = 1; my = 0;
            end else if (mx == W-1) begin
               if (l) begin
                  wr = 1; a = my*W + mx; mx = 0;
                  if (my == H-1) begin fd = 1; m_fcnt++; my = 0; m_state = 0; end
                  else my++;
               end else begin
                  el = 1; m_state = 2;
               end
            end else if (l) begin
               ee = 1; wr = 1; a = my*W + mx; mx = 0;
               if (my == H-1) begin my = 0; m_state = 0; end
               else my++;
            end else begin
               wr = 1; a = my*W + mx; mx++;
            end
         end
         default: begin
            if (u) begin
               es = 1; wr = 1; a = 0; mx = 1; my = 0; m_state = 1;
            end else if (l) begin
               mx = 0;
               if (my == H-1) begin my = 0; m_state = 0; end
               else begin my++; m_state = 1; end
            end
         end
      endcase
      if (clr) model_clear();
      if (es | ee | el) begin
         m_sof   |= es;
         m_early |= ee;
         m_late  |= el;
         if (m_ecnt != 16'hFFFF) m_ecnt++;
      end
      if (wr) q.push_back('{addr: AW'(a), data: d, fd: fd});
   endtask

   task automatic idle_cycles(input int n);
      s_video_tvalid = 1'b0;
      repeat (n) begin @(posedge sys_clk); #1; end
   endtask

   task automatic send_beat(input bit u, input bit l, input bit clr = 1'b0);
      logic [7:0] d;
      bit acc;
      int w = 0;
      d = 8'($urandom);
      s_video_tdata  = d;
      s_video_tuser  = u;
      s_video_tlast  = l;
      s_video_tvalid = 1'b1;
      err_clr        = clr;
      do begin
         acc = s_video_tready;
         @(posedge sys_clk); #1;
         w++;
      end while (!acc && w < 100);
      check_eq("beat_accept", 32'(acc), 32'd1);
      if (acc) model_beat(d, u, l, clr);
      s_video_tvalid = 1'b0;
      s_video_tuser  = 1'b0;
      s_video_tlast  = 1'b0;
      err_clr        = 1'b0;
   endtask

   task automatic send_px(input int from, input int to);
      for (int p = from; p < to; p++) send_beat(p == 0, (p % W) == W-1);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(posedge sys_clk); #1;
      err_clr = 1'b0;
      model_clear();
   endtask

   task automatic check_status(input string tag);
      idle_cycles(3);
      check_eq({tag, "_fcnt"},   32'(frame_cnt),     32'(m_fcnt));
      check_eq({tag, "_sof"},    32'(err_sof_early), 32'(m_sof));
      check_eq({tag, "_early"},  32'(err_eol_early), 32'(m_early));
      check_eq({tag, "_late"},   32'(err_eol_late),  32'(m_late));
      check_eq({tag, "_errcnt"}, 32'(err_cnt),       32'(m_ecnt));
      check_eq({tag, "_sb"},     32'(q.size()),      32'd0);
   endtask

   initial begin
      sys_aresetn    = 1'b0;
      en             = 1'b0;
      s_video_tdata  = '0;
      s_video_tvalid = 1'b0;
      s_video_tlast  = 1'b0;
      s_video_tuser  = 1'b0;
      err_clr        = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      check_eq("rst_tready",  32'(s_video_tready), 32'd0);
      check_eq("rst_wr_en",   32'(wr_en),          32'd0);
      check_eq("rst_wr_addr", 32'(wr_addr),        32'd0);
      check_eq("rst_fcnt",    32'(frame_cnt),      32'd0);
      check_eq("rst_errcnt",  32'(err_cnt),        32'd0);
      check_eq("rst_flags",   32'({err_sof_early, err_eol_early, err_eol_late}), 32'd0);
      sys_aresetn = 1'b1;
      en          = 1'b1;
      idle_cycles(2);

      // clean frame, continuous valid
      send_px(0, W*H);
      check_status("clean");

      // valid gaps inside the frame
      for (int p = 0; p < W*H; p++) begin
         if (p == 2 || p == 7)      idle_cycles(1);
         else if (p == 5)           idle_cycles(3);
         else if (p == 19)          idle_cycles(2);
         send_beat(p == 0, (p % W) == W-1);
      end
      check_status("gaps");

      // leading beats without tuser are dropped
      repeat (3) send_beat(1'b0, 1'b0);
      send_px(0, W*H);
      check_status("lead");

      // early tlast at line 2, x=5
      send_px(0, 2*W);
      for (int x = 0; x <= 5; x++) send_beat(1'b0, x == 5);
      send_px(3*W, W*H);
      check_status("eol_early");
      pulse_clr();
      check_status("clr1");

      // missing tlast at line 4, tlast two beats later
      send_px(0, 4*W);
      for (int x = 0; x < W; x++) send_beat(1'b0, 1'b0);
      send_beat(1'b0, 1'b0);
      send_beat(1'b0, 1'b1);
      send_px(5*W, W*H);
      check_status("eol_late");

      // missing tlast on the last line runs the line count out
      send_px(0, (H-1)*W);
      for (int x = 0; x < W; x++) send_beat(1'b0, 1'b0);
      send_beat(1'b0, 1'b1);
      repeat (2) send_beat(1'b0, 1'b0);
      check_status("late_last");

      // tuser mid-frame restarts the frame
      send_px(0, 6*W + 3);
      send_beat(1'b1, 1'b0);
      check_status("sof_early");
      pulse_clr();
      check_status("clr2");
      send_px(1, W*H);
      check_status("sof_done");

      // error in the same cycle as err_clr
      send_px(0, 4*W);
      for (int x = 0; x < W; x++) send_beat(1'b0, 1'b0);
      send_beat(1'b1, 1'b0, 1'b1);
      send_px(1, W*H);
      check_status("clr_collide");

      // enable dropped mid-frame
      send_px(0, 45);
      en = 1'b0;
      fork
         begin
            repeat (6) @(posedge sys_clk);
            #1 en = 1'b1;
         end
      join_none
      send_px(45, W*H);
      check_status("en_pause");

      // reset mid-frame
      send_px(0, 25);
      idle_cycles(3);
      check_eq("pre_rst_sb", 32'(q.size()), 32'd0);
      sys_aresetn = 1'b0;
      #1;
      check_eq("mid_rst_fcnt",   32'(frame_cnt), 32'd0);
      check_eq("mid_rst_errcnt", 32'(err_cnt),   32'd0);
      check_eq("mid_rst_wr_en",  32'(wr_en),     32'd0);
      check_eq("mid_rst_tready", 32'(s_video_tready), 32'd0);
      @(posedge sys_clk); #1;
      sys_aresetn = 1'b1;
      m_state = 0; mx = 0; my = 0; m_fcnt = '0;
      model_clear();
      send_px(0, W*H);
      check_status("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
